// File: rtl/gemm_rd_adapter_pkg.sv
// rtl/gemm_rd_adapter_pkg.sv - shared constants for the GEMM read-channel adapter
package gemm_pkg;

   localparam int DATA_W   = 128;
   localparam int BYTE_OFS = 4;

   localparam int ERR_W        = 3;
   localparam int ERR_DROP     = 0;
   localparam int ERR_MISALIGN = 1;
   localparam int ERR_UNSOL    = 2;

   // A GEMM byte address must land on a 128-bit word boundary.
   function automatic logic misaligned(input logic [31:0] byte_addr);
      return byte_addr[BYTE_OFS-1:0] != '0;
   endfunction

endpackage

// File: rtl/gemm_rd_adapter_if.sv
// rtl/gemm_rd_adapter_if.sv - GEMM-side and memory-side read channel signals
interface gemm_rd_adapter_if #(
   parameter int MEM_AW = 28
);
   import gemm_pkg::*;

   logic                vsi_start;
   logic                vsi_raddr_valid;
   logic [31:0]         vsi_raddr;
   logic                vsi_rdata_valid;
   logic [DATA_W-1:0]   vsi_rdata;
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [MEM_AW-1:0]   mem_req_addr;
   logic                mem_rsp_valid;
   logic [DATA_W-1:0]   mem_rsp_data;
   logic [3:0]          outst_cnt;
   logic [ERR_W-1:0]    err_flags;

   // Environment side: GEMM requests, memory ready and responses.
   modport master (
      output vsi_start, vsi_raddr_valid, vsi_raddr,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  vsi_rdata_valid, vsi_rdata, mem_req_valid, mem_req_addr,
      input  outst_cnt, err_flags
   );

   // Adapter side.
   modport slave (
      input  vsi_start, vsi_raddr_valid, vsi_raddr,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output vsi_rdata_valid, vsi_rdata, mem_req_valid, mem_req_addr,
      output outst_cnt, err_flags
   );

endinterface

// File: rtl/gemm_rd_adapter_sync_fifo.sv
// rtl/gemm_rd_adapter_sync_fifo.sv - synchronous FIFO, push accepted on full when popping
module gemm_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset empties the FIFO immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents are only observed through valid pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gemm_rd_adapter.sv
// rtl/gemm_rd_adapter.sv - queues GEMM reads, issues to SRAM with an in-flight cap, returns data in order
module gemm_rd_adapter
   import gemm_pkg::*;
#(
   parameter int REQ_DEPTH = 4,
   parameter int MAX_OUTST = 8,
   parameter int MEM_AW    = 28
) (
   input  logic              vsi_clk,
   input  logic              vsi_reset_n,
   gemm_rd_adapter_if.slave  bus
);
   logic [MEM_AW-1:0] head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              issue;
   logic              rsp_ok;
   logic              rsp_unsol;
   logic [3:0]        outst_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ERR_W-1:0]  err_q;
   logic [ERR_W-1:0]  err_set;

   gemm_sync_fifo #(
      .WIDTH (MEM_AW),
      .DEPTH (REQ_DEPTH)
   ) u_req_fifo (
      .clk   (vsi_clk),
      .rst_n (vsi_reset_n),
      .push  (bus.vsi_raddr_valid),
      .pop   (issue),
      .din   (bus.vsi_raddr[MEM_AW+BYTE_OFS-1:BYTE_OFS]),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Request side depends only on registered state, never on mem_req_ready.
   assign bus.mem_req_valid = ~fifo_empty & (outst_q < 4'(MAX_OUTST));
   assign bus.mem_req_addr  = fifo_empty ? '0 : head;
   assign issue             = bus.mem_req_valid & bus.mem_req_ready;

   // A response only counts when something is actually in flight.
   assign rsp_ok    = bus.mem_rsp_valid & (outst_q != 4'd0);
   assign rsp_unsol = bus.mem_rsp_valid & (outst_q == 4'd0);

   // Collect this cycle's error events.
   always_comb begin
      err_set               = '0;
      err_set[ERR_DROP]     = bus.vsi_raddr_valid & fifo_full & ~issue;
      err_set[ERR_MISALIGN] = bus.vsi_raddr_valid & misaligned(bus.vsi_raddr);
      err_set[ERR_UNSOL]    = rsp_unsol;
   end

   // In-flight counter; the issue gate and rsp_ok keep it inside 0..MAX_OUTST.
   always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
      if (!vsi_reset_n) begin
         outst_q <= '0;
      end else if (issue && !rsp_ok) begin
         outst_q <= outst_q + 4'd1;
      end else if (!issue && rsp_ok) begin
         outst_q <= outst_q - 4'd1;
      end
   end

   // Registered response to GEMM; data holds between pulses.
   always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
      if (!vsi_reset_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rsp_ok;
         if (rsp_ok) rdata_q <= bus.mem_rsp_data;
      end
   end

   // Sticky error flags; a new event beats a simultaneous start clear.
   always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
      if (!vsi_reset_n) begin
         err_q <= '0;
      end else begin
         err_q <= (err_q & ~{ERR_W{bus.vsi_start}}) | err_set;
      end
   end

   assign bus.outst_cnt       = outst_q;
   assign bus.vsi_rdata_valid = rvalid_q;
   assign bus.vsi_rdata       = rdata_q;
   assign bus.err_flags       = err_q;

endmodule

// File: tb/tb_gemm_rd_adapter.sv
// tb/tb_gemm_rd_adapter.sv - directed self-checking bench for gemm_rd_adapter
module tb_gemm_rd_adapter;
   import gemm_pkg::*;

   localparam int AW = 28;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   gemm_rd_adapter_if #(.MEM_AW(AW)) bus ();

   gemm_rd_adapter #(
      .REQ_DEPTH (4),
      .MAX_OUTST (8),
      .MEM_AW    (AW)
   ) dut (
      .vsi_clk     (clk),
      .vsi_reset_n (rst_n),
      .bus         (bus.slave)
   );

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
   } rsp_t;

   typedef struct {
      logic [31:0]   addr;
      int            lat;
      logic [AW-1:0] exp_addr;
      logic [2:0]    exp_err;
   } vec_t;

   int             errors = 0;
   int             checks = 0;
   int             cyc_n = 0;
   int             lat = 1;
   int             rsp_allow = 1000000;
   bit             force_rsp = 1'b0;
   int             t0;
   rsp_t           rspq[$];
   logic [AW-1:0]  issued[$];
   int             issue_cyc[$];
   logic [127:0]   got[$];
   int             got_cyc[$];
   vec_t           vt[5];

   function automatic logic [127:0] mk_data(input logic [AW-1:0] a);
      logic [31:0] w;
      w = {4'h0, a};
      return {w, 32'hDEAD_BEEF ^ w, ~w, 32'h0123_4567 + w};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clr();
      rspq.delete();
      issued.delete();
      issue_cyc.delete();
      got.delete();
      got_cyc.delete();
   endtask

   // One clock: present memory response, log handshakes, then sample outputs.
   task automatic tick();
      bus.mem_rsp_valid = 1'b0;
      if (force_rsp) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = 128'hBAD0_0000;
      end else if (rsp_allow > 0 && rspq.size() > 0 && rspq[0].due <= cyc_n) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = mk_data(rspq[0].addr);
         void'(rspq.pop_front());
         rsp_allow--;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         issued.push_back(bus.mem_req_addr);
         issue_cyc.push_back(cyc_n);
         rspq.push_back('{cyc_n + lat, bus.mem_req_addr});
      end
      @(posedge clk);
      #1;
      cyc_n++;
      bus.mem_rsp_valid = 1'b0;
      if (bus.vsi_rdata_valid) begin
         got.push_back(bus.vsi_rdata);
         got_cyc.push_back(cyc_n);
      end
   endtask

   task automatic req(input logic [31:0] a);
      bus.vsi_raddr_valid = 1'b1;
      bus.vsi_raddr       = a;
      tick();
      bus.vsi_raddr_valid = 1'b0;
   endtask

   task automatic start_pulse();
      bus.vsi_start = 1'b1;
      tick();
      bus.vsi_start = 1'b0;
   endtask

   task automatic drain(input int n);
      int b;
      b = 0;
      while (got.size() < n && b < 300) begin
         tick();
         b++;
      end
      chk("drain_count", 128'(got.size()), 128'(n));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdata_valid"}, 128'(bus.vsi_rdata_valid), 128'(0));
      chk({tag, "_rdata"},       bus.vsi_rdata,              128'(0));
      chk({tag, "_req_valid"},   128'(bus.mem_req_valid),   128'(0));
      chk({tag, "_req_addr"},    128'(bus.mem_req_addr),    128'(0));
      chk({tag, "_outst"},       128'(bus.outst_cnt),       128'(0));
      chk({tag, "_err"},         128'(bus.err_flags),       128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vt[0] = '{32'h0000_0040, 3, 28'h000_0004, 3'b000};
      vt[1] = '{32'h0000_0044, 1, 28'h000_0004, 3'b010};
      vt[2] = '{32'hFFFF_FFF0, 2, 28'hFFF_FFFF, 3'b000};
      vt[3] = '{32'h1234_5678, 4, 28'h123_4567, 3'b010};
      vt[4] = '{32'h0000_0000, 1, 28'h000_0000, 3'b000};

      bus.vsi_start       = 1'b0;
      bus.vsi_raddr_valid = 1'b0;
      bus.vsi_raddr       = '0;
      bus.mem_req_ready   = 1'b0;
      bus.mem_rsp_valid   = 1'b0;
      bus.mem_rsp_data    = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Single reads from the vector table.
      for (int i = 0; i < 5; i++) begin
         lat = vt[i].lat;
         clr();
         start_pulse();
         bus.mem_req_ready   = 1'b1;
         t0                  = cyc_n;
         bus.vsi_raddr_valid = 1'b1;
         bus.vsi_raddr       = vt[i].addr;
         chk("no_bypass", 128'(bus.mem_req_valid), 128'(0));
         tick();
         bus.vsi_raddr_valid = 1'b0;
         chk("req_valid_t1", 128'(bus.mem_req_valid), 128'(1));
         chk("req_addr_t1", 128'(bus.mem_req_addr), 128'(vt[i].exp_addr));
         drain(1);
         if (got.size() > 0) begin
            chk("single_data", got[0], mk_data(vt[i].exp_addr));
            chk("single_latency", 128'(got_cyc[0] - t0), 128'(2 + vt[i].lat));
         end
         chk("single_outst", 128'(bus.outst_cnt), 128'(0));
         chk("single_err", 128'(bus.err_flags), 128'(vt[i].exp_err));
         tick();
         chk("single_pulse", 128'(got.size()), 128'(1));
      end

      // Back-to-back, latency 2.
      lat = 2;
      clr();
      start_pulse();
      t0 = cyc_n;
      for (int i = 0; i < 8; i++) req(32'(i * 16));
      drain(8);
      chk("b2b_issues", 128'(issued.size()), 128'(8));
      for (int i = 0; i < issued.size(); i++) begin
         chk("b2b_addr", 128'(issued[i]), 128'(i));
         chk("b2b_issue_cyc", 128'(issue_cyc[i]), 128'(t0 + 1 + i));
      end
      for (int i = 0; i < got.size(); i++) chk("b2b_data", got[i], mk_data(AW'(i)));
      chk("b2b_err", 128'(bus.err_flags), 128'(0));

      // Overflow, then push-on-full with a same-cycle pop.
      lat = 1;
      clr();
      start_pulse();
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 6; i++) req(32'h100 + 32'(i * 16));
      chk("ovf_err", 128'(bus.err_flags), 128'(3'b001));
      chk("ovf_no_issue", 128'(issued.size()), 128'(0));
      chk("ovf_head", 128'(bus.mem_req_addr), 128'(28'h10));
      start_pulse();
      chk("ovf_cleared", 128'(bus.err_flags), 128'(0));
      bus.mem_req_ready = 1'b1;
      req(32'h200);
      chk("full_pop_push_err", 128'(bus.err_flags), 128'(0));
      drain(5);
      chk("ovf_issues", 128'(issued.size()), 128'(5));
      for (int i = 0; i < issued.size(); i++)
         chk("ovf_order", 128'(issued[i]), 128'((i < 4) ? (28'h10 + 28'(i)) : 28'h20));

      // Outstanding cap with responses withheld.
      clr();
      start_pulse();
      rsp_allow = 0;
      for (int i = 0; i < 10; i++) req(32'h1000 + 32'(i * 16));
      repeat (3) tick();
      chk("cap_issues", 128'(issued.size()), 128'(8));
      chk("cap_outst", 128'(bus.outst_cnt), 128'(8));
      chk("cap_valid", 128'(bus.mem_req_valid), 128'(0));
      chk("cap_head", 128'(bus.mem_req_addr), 128'(28'h108));
      rsp_allow = 1;
      tick();
      chk("cap_outst_dec", 128'(bus.outst_cnt), 128'(7));
      chk("cap_reenable", 128'(bus.mem_req_valid), 128'(1));
      rsp_allow = 1000000;
      drain(10);
      chk("cap_total_issues", 128'(issued.size()), 128'(10));
      for (int i = 0; i < got.size(); i++) chk("cap_data", got[i], mk_data(28'h100 + AW'(i)));
      chk("cap_outst_end", 128'(bus.outst_cnt), 128'(0));
      chk("cap_err", 128'(bus.err_flags), 128'(0));

      // Unsolicited response, start clear, and set-beats-clear.
      clr();
      force_rsp = 1'b1;
      tick();
      force_rsp = 1'b0;
      chk("unsol_no_data", 128'(got.size()), 128'(0));
      chk("unsol_err", 128'(bus.err_flags), 128'(3'b100));
      chk("unsol_outst", 128'(bus.outst_cnt), 128'(0));
      start_pulse();
      chk("start_clear", 128'(bus.err_flags), 128'(0));
      bus.vsi_start = 1'b1;
      force_rsp     = 1'b1;
      tick();
      bus.vsi_start = 1'b0;
      force_rsp     = 1'b0;
      chk("set_wins", 128'(bus.err_flags), 128'(3'b100));
      start_pulse();

      // Asynchronous reset with three reads in flight and one queued.
      clr();
      rsp_allow = 0;
      for (int i = 0; i < 3; i++) req(32'h300 + 32'(i * 16));
      tick();
      bus.mem_req_ready = 1'b0;
      req(32'h334);
      chk("pre_rst_outst", 128'(bus.outst_cnt), 128'(3));
      chk("pre_rst_valid", 128'(bus.mem_req_valid), 128'(1));
      chk("pre_rst_err", 128'(bus.err_flags), 128'(3'b010));
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      cyc_n++;
      rst_n = 1'b1;
      clr();
      rsp_allow = 1000000;
      force_rsp = 1'b1;
      tick();
      force_rsp = 1'b0;
      chk("stray_err", 128'(bus.err_flags), 128'(3'b100));
      chk("stray_no_data", 128'(got.size()), 128'(0));
      chk("stray_outst", 128'(bus.outst_cnt), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gemm_rd_adapter.md
# gemm_rd_adapter

Read-channel adapter between the GEMM engine's read interface and the on-chip matrix SRAM port. GEMM issues fire-and-forget read requests with no back-pressure, so this block queues them in a small request FIFO, issues them to memory under a ready/valid handshake with an outstanding-request limit, and returns responses to GEMM in order, registered. It also flags dropped requests, misaligned addresses and unsolicited responses.

## Interface
Parameters:
- REQ_DEPTH, 4: request FIFO depth (power of two, ≥2).
- MAX_OUTST, 8: maximum memory requests in flight (≤15).
- MEM_AW, 28: memory word-address width (128-bit words).

Ports:
- vsi_clk  in  1  single clock; all logic on the rising edge.
- vsi_reset_n  in  1  asynchronous, active-low reset.
- vsi_start  in  1  pulse; clears the sticky error flags.
- vsi_raddr_valid  in  1  GEMM read request strobe.
- vsi_raddr  in  32  GEMM byte address.
- vsi_rdata_valid  out  1  read data strobe to GEMM.
- vsi_rdata  out  128  read data to GEMM.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  MEM_AW  word address = vsi_raddr[MEM_AW+3:4].
- mem_rsp_valid  in  1  in-order memory response strobe (no ready).
- mem_rsp_data  in  128  memory response data.
- outst_cnt  out  4  current in-flight count.
- err_flags  out  3  sticky: [0] request dropped (FIFO full), [1] misaligned address, [2] unsolicited response.

## Operation
- Push: `vsi_raddr_valid` writes the word address into the FIFO. Push is allowed when not full, or when full and a pop occurs in the same cycle.
- Dropped request: push while full with no pop. Request is discarded, err_flags[0] is set, FIFO is unchanged.
- Misaligned address: vsi_raddr[3:0]≠0. Sets err_flags[1]; the request is still queued with the truncated word address.
- Issue:
  - mem_req_valid = FIFO not empty AND outst_cnt < MAX_OUTST.
  - mem_req_addr = FIFO head.
  - Pop on mem_req_valid & mem_req_ready.
  - Valid and address are held stable until accepted.
- Outstanding counter:
  - +1 on an issue handshake; −1 on mem_rsp_valid; unchanged when both occur in the same cycle.
  - Never wraps.
- Response path:
  - mem_rsp_valid with outst_cnt>0 registers mem_rsp_data into vsi_rdata and pulses vsi_rdata_valid for one cycle.
  - vsi_rdata holds its last value otherwise.
- Unsolicited response: mem_rsp_valid with outst_cnt==0. The response is dropped (no vsi_rdata_valid), err_flags[2] is set, and the counter stays 0.
- Sticky flags:
  - Cleared by vsi_start.
  - A set event and vsi_start in the same cycle: set wins.
- No state machine beyond the FIFO pointers and counter; the block is always ready.

## Timing
- Reset values: vsi_rdata_valid=0, vsi_rdata=0, mem_req_valid=0, mem_req_addr=0, outst_cnt=0, err_flags=0, FIFO empty.
- Request latency:
  - Request at cycle T gives mem_req_valid at T+1 at the earliest. There is no same-cycle bypass.
  - With ready held high, one request per cycle is sustained.
- Response latency: mem_rsp_valid at cycle R gives vsi_rdata_valid at R+1.
- End-to-end minimum: 2 cycles plus the memory latency.
- mem_req_valid and mem_req_addr are driven combinationally from registered state only. There is no combinational path from mem_req_ready to mem_req_valid.
- Reset mid-operation: FIFO and counter are cleared immediately and in-flight responses are lost. Responses arriving after reset release count as unsolicited.

## Structure
- Package gemm_pkg holds:
  - DATA_W=128 and BYTE_OFS=4.
  - Error-bit index constants ERR_DROP, ERR_MISALIGN, ERR_UNSOL.
- Sub-module gemm_sync_fifo: parameterised width and depth; push/pop/full/empty with a same-cycle push-on-full-with-pop rule. It is reused for the write path later.
- Top level holds the counter, the response register and the flags.

## Test plan
- Single read at 0x0000_0040, memory latency 3, ready=1:
  - mem_req_addr=0x4 at T+1.
  - vsi_rdata_valid at T+5 carrying the memory data.
  - outst_cnt returns to 0.
- Back-to-back: 8 requests 0x000..0x070, ready=1, latency 2 → 8 consecutive issues, 8 in-order responses, no errors.
- Overflow: ready=0, 6 consecutive requests → first 4 queued, err_flags[0]=1. Then ready=1 → exactly 4 issues, in order.
- Outstanding cap: MAX_OUTST=8, responses withheld, 10 requests → mem_req_valid drops after 8 issues and outst_cnt=8. A response re-enables issue the next cycle.
- Error cases:
  - vsi_raddr=0x0000_0044 → err_flags[1]=1, mem_req_addr=0x4.
  - mem_rsp_valid with outst_cnt=0 → err_flags[2]=1, no vsi_rdata_valid.
  - vsi_start → err_flags=0.
- Async reset asserted with 3 in flight → outputs at reset values immediately. After release, a stray response sets err_flags[2].
